// File: rtl/pulse_mon_pkg.sv
// Shared types and defaults for the pulse width monitor and its receive-side helpers.
package pulse_mon_pkg;

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   localparam int DEF_CNT_W        = 16;
   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_EXP_HIGH_CYC = 10;
   localparam int DEF_EXP_LOW_CYC  = 10;
   localparam int DEF_TOL_CYC      = 1;
   localparam int DEF_TIMEOUT_CYC  = 64;

   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
   } win_t;

   // Unsigned acceptance window; the lower bound clamps at zero instead of wrapping.
   function automatic win_t tol_window(input int unsigned exp_cyc, input int unsigned tol);
      win_t w;
      w.lo = (exp_cyc > tol) ? exp_cyc - tol : 32'd0;
      w.hi = exp_cyc + tol;
      return w;
   endfunction

endpackage

// File: rtl/pulse_sync.sv
// Multi-flop synchroniser for an asynchronous level, followed by rise/fall detection.
module pulse_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pulse,
   output logic s,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              s_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         chain <= '0;
         s_d   <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], pulse};
         s_d   <= chain[STAGES-1];
      end
   end

   assign s    = chain[STAGES-1];
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

endmodule

// File: rtl/pulse_width_monitor.sv
// Measures high/low phase widths of a synchronised pulse, counts periods, flags tolerance/stuck/gating errors.
module pulse_width_monitor
   import pulse_mon_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int EXP_HIGH_CYC = DEF_EXP_HIGH_CYC,
   parameter int EXP_LOW_CYC  = DEF_EXP_LOW_CYC,
   parameter int TOL_CYC      = DEF_TOL_CYC,
   parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pulse_in,
   input  logic             gen_enable,
   input  logic             err_clr,
   output logic             meas_valid,
   output logic             meas_is_high,
   output logic [CNT_W-1:0] meas_width,
   output logic [CNT_W-1:0] period_count,
   output logic             high_err,
   output logic             low_err,
   output logic             stuck_err,
   output logic             gate_err
);

   localparam int   DIS_MAX = SYNC_STAGES + 2;
   localparam int   DIS_W   = $clog2(DIS_MAX + 1);
   localparam win_t HI_WIN  = tol_window(EXP_HIGH_CYC, TOL_CYC);
   localparam win_t LO_WIN  = tol_window(EXP_LOW_CYC, TOL_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic s, rise, fall;

   pulse_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .pulse   (pulse_in),
      .s       (s),
      .rise    (rise),
      .fall    (fall)
   );

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DIS_W-1:0]  dis_cnt;
   logic [31:0]       mw32;
   logic              timeout, hi_set, lo_set, stuck_set, gate_set;

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   // Widened compare: a timeout beyond the counter range simply never fires.
   assign timeout = (32'(cnt) == TIMEOUT_CYC);
   assign mw32    = 32'(meas_width);

   // Tolerance checks look at the registered report, so errors land one cycle after the strobe.
   assign hi_set    = meas_valid &  meas_is_high & ((mw32 < HI_WIN.lo) | (mw32 > HI_WIN.hi));
   assign lo_set    = meas_valid & ~meas_is_high & ((mw32 < LO_WIN.lo) | (mw32 > LO_WIN.hi));
   assign stuck_set = gen_enable & timeout &
                      (((state == HIGH) & ~fall) | ((state == LOW) & ~rise));
   // Waiting out the synchroniser depth after disable hides residue from the last enabled pulse.
   assign gate_set  = ~gen_enable & s & (dis_cnt == DIS_W'(DIS_MAX));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         dis_cnt      <= '0;
         meas_valid   <= 1'b0;
         meas_is_high <= 1'b0;
         meas_width   <= '0;
         period_count <= '0;
         high_err     <= 1'b0;
         low_err      <= 1'b0;
         stuck_err    <= 1'b0;
         gate_err     <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         high_err   <= (high_err  & ~err_clr) | hi_set;
         low_err    <= (low_err   & ~err_clr) | lo_set;
         stuck_err  <= (stuck_err & ~err_clr) | stuck_set;
         gate_err   <= (gate_err  & ~err_clr) | gate_set;

         if (!gen_enable) begin
            state <= IDLE;
            cnt   <= '0;
            if (dis_cnt != DIS_W'(DIS_MAX))
               dis_cnt <= dis_cnt + DIS_W'(1);
         end else begin
            dis_cnt <= '0;
            case (state)
               IDLE: begin
                  if (rise) begin
                     state <= HIGH;
                     cnt   <= CNT_W'(1);
                  end
               end
               HIGH: begin
                  if (fall) begin
                     meas_valid   <= 1'b1;
                     meas_is_high <= 1'b1;
                     meas_width   <= cnt;
                     state        <= LOW;
                     cnt          <= CNT_W'(1);
                  end else if (timeout) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               LOW: begin
                  if (rise) begin
                     meas_valid   <= 1'b1;
                     meas_is_high <= 1'b0;
                     meas_width   <= cnt;
                     period_count <= period_count + CNT_W'(1);
                     state        <= HIGH;
                     cnt          <= CNT_W'(1);
                  end else if (timeout) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule
